// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch front end: FSM encoding, reset PC and word size.
package if_fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam int          WORD_BYTES       = 4;

endpackage

// File: rtl/if_fetch_stage_fifo.sv
// Small power-of-two FIFO holding {pc, instruction} pairs for the decoder; flush empties it in one cycle.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && !empty;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage is data only; validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !flush));

endmodule

// File: rtl/if_fetch_stage_mux2.sv
// Two-input word multiplexer used for the next-PC choice (sel=0 -> a, sel=1 -> b).
module Mux2 #(
    parameter int WIDTH = 32
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch front end: PC register, single-outstanding fetch FSM and a decoder-side output buffer.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT),
    parameter int               DEPTH    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             W_redirect,
    input  logic [WIDTH-1:0] W_redirect_pc,
    output logic             W_imem_req,
    output logic [WIDTH-1:0] W_imem_addr,
    input  logic             W_imem_gnt,
    input  logic             W_imem_rvalid,
    input  logic [WIDTH-1:0] W_imem_rdata,
    output logic             W_inst_valid,
    input  logic             W_inst_ready,
    output logic [WIDTH-1:0] W_inst,
    output logic [WIDTH-1:0] W_inst_pc
);

    localparam int               CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_state_e       state_q;
    fetch_state_e       state_d;
    logic [WIDTH-1:0]   pc_q;
    logic [WIDTH-1:0]   req_pc_q;
    logic [WIDTH-1:0]   pc_plus4;
    logic [WIDTH-1:0]   redirect_aligned;
    logic [WIDTH-1:0]   pc_next;
    logic               granted;
    logic               pc_load;
    logic               push;
    logic               pop;
    logic               credit_ok;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W-1:0]   count_after;
    logic [2*WIDTH-1:0] fifo_head;

    assign pc_plus4         = pc_q + WIDTH'(WORD_BYTES);
    assign redirect_aligned = W_redirect_pc & ~WIDTH'(WORD_BYTES - 1);

    Mux2 #(.WIDTH(WIDTH)) u_next_pc_mux (
        .sel (W_redirect),
        .a   (pc_plus4),
        .b   (redirect_aligned),
        .y   (pc_next)
    );

    assign granted = (state_q == ST_REQ) && W_imem_gnt;
    assign pc_load = W_redirect || granted;

    // A redirect squashes both the incoming response and any same-cycle pop.
    assign push = (state_q == ST_WAIT) && W_imem_rvalid && !W_redirect;
    assign pop  = !fifo_empty && W_inst_ready && !W_redirect;

    // Occupancy after this edge decides whether another fetch may be issued.
    assign count_after = fifo_count + CNT_W'(push) - CNT_W'(pop);
    assign credit_ok   = (count_after < DEPTH_C);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (pc_load) begin
            pc_q <= pc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (granted) req_pc_q <= pc_q;
    end

    fetch_fifo #(.WIDTH(2 * WIDTH), .DEPTH(DEPTH)) u_fetch_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (W_redirect),
        .push  (push),
        .pop   (pop),
        .wdata ({req_pc_q, W_imem_rdata}),
        .rdata (fifo_head),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (W_redirect || credit_ok) state_d = ST_REQ;
            ST_REQ:  if (W_imem_gnt) state_d = W_redirect ? ST_DROP : ST_WAIT;
            ST_WAIT: begin
                if (W_imem_rvalid)   state_d = (W_redirect || credit_ok) ? ST_REQ : ST_IDLE;
                else if (W_redirect) state_d = ST_DROP;
            end
            // Once the stale response has arrived nothing is outstanding, so fetch can resume.
            ST_DROP: if (W_imem_rvalid) state_d = ST_REQ;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        W_imem_req   = (state_q == ST_REQ);
        W_imem_addr  = pc_q;
        W_inst_valid = !fifo_empty;
        W_inst       = fifo_empty ? '0 : fifo_head[WIDTH-1:0];
        W_inst_pc    = fifo_empty ? '0 : fifo_head[2*WIDTH-1:WIDTH];
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus randomized memory/decoder timing against a stream-level model.
module tb_if_fetch_stage;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    always #5 clk = ~clk;

    if_fetch_stage #(.WIDTH(32), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .W_redirect    (redirect),
        .W_redirect_pc (redirect_pc),
        .W_imem_req    (imem_req),
        .W_imem_addr   (imem_addr),
        .W_imem_gnt    (imem_gnt),
        .W_imem_rvalid (imem_rvalid),
        .W_imem_rdata  (imem_rdata),
        .W_inst_valid  (inst_valid),
        .W_inst_ready  (inst_ready),
        .W_inst        (inst),
        .W_inst_pc     (inst_pc)
    );

    int errors = 0;
    int checks = 0;

    // Stream-level reference: delivered words, one possible in-flight fetch, next sequential fetch PC.
    ent_t        q[$];
    bit          out_busy, out_stale;
    logic [31:0] out_pc, next_fetch;
    // Memory model and knobs.
    bit          mem_busy;
    logic [31:0] mem_addr;
    int          mem_lat;
    int          gnt_pct, ready_pct, lat_min, lat_max;
    // Observation logs.
    int          cyc, first_gnt_cyc, last_drop_cyc, n_pops, n_drops;
    logic [31:0] popped_pc[$];
    int          pop_cyc[$];
    logic [31:0] gnt_log[$];

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_inst_valid", 32'(inst_valid), 0);
        check("rst_imem_req", 32'(imem_req), 0);
        check("rst_inst", inst, 0);
        check("rst_inst_pc", inst_pc, 0);
        rst = 1'b0;
        q.delete(); out_busy = 0; out_stale = 0; next_fetch = RESET_PC;
        mem_busy = 0; mem_lat = 0; first_gnt_cyc = -1;
    endtask

    task automatic cycle(input bit redir, input logic [31:0] tgt);
        bit          v_valid, v_req, g, rv, rdy, pop;
        logic [31:0] v_addr;
        check("inst_valid", 32'(inst_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            check("inst", inst, q[0].data);
            check("inst_pc", inst_pc, q[0].pc);
        end else begin
            check("inst_empty", inst, 0);
            check("inst_pc_empty", inst_pc, 0);
        end
        if (imem_req) check("fetch_addr", imem_addr, next_fetch);
        if (q.size() + int'(out_busy) >= DEPTH) check("req_without_credit", 32'(imem_req), 0);
        v_valid = inst_valid; v_req = imem_req; v_addr = imem_addr;
        rdy = ($urandom_range(99) < ready_pct);
        rv  = mem_busy && (mem_lat == 0);
        g   = v_req && ($urandom_range(99) < gnt_pct);
        redirect = redir; redirect_pc = tgt;
        imem_gnt = g; imem_rvalid = rv; imem_rdata = rv ? word(mem_addr) : $urandom;
        inst_ready = rdy;
        @(posedge clk);
        pop = v_valid && rdy && !redir;
        if (pop && q.size() > 0) begin
            popped_pc.push_back(q[0].pc); pop_cyc.push_back(cyc);
            void'(q.pop_front()); n_pops++;
        end
        if (rv) begin
            if (!redir && !out_stale) q.push_back('{out_pc, word(out_pc)});
            else begin n_drops++; last_drop_cyc = cyc; end
            out_busy = 0;
        end
        if (g) begin
            out_busy = 1; out_stale = redir; out_pc = next_fetch; next_fetch += 32'd4;
            gnt_log.push_back(v_addr);
            if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
        end
        if (redir) begin
            q.delete();
            if (out_busy) out_stale = 1;
            next_fetch = tgt & ~32'h3;
        end
        if (rv) mem_busy = 0;
        if (g) begin
            mem_busy = 1; mem_addr = v_addr; mem_lat = $urandom_range(lat_max, lat_min);
        end else if (mem_busy && mem_lat > 0) begin
            mem_lat--;
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        int p0, d0;
        cyc = 0; n_pops = 0; n_drops = 0; last_drop_cyc = -1;
        gnt_pct = 100; ready_pct = 100; lat_min = 0; lat_max = 0;
        do_reset();

        // Zero-wait memory, decoder always ready: sequential words every two cycles.
        for (int k = 0; k < 40 && popped_pc.size() < 3; k++) cycle(0, 0);
        check("t1_npops", popped_pc.size(), 3);
        if (popped_pc.size() >= 3) begin
            check("t1_pc0", popped_pc[0], 32'hBFC0_0000);
            check("t1_pc1", popped_pc[1], 32'hBFC0_0004);
            check("t1_pc2", popped_pc[2], 32'hBFC0_0008);
            check("t1_latency", 32'(pop_cyc[0] - first_gnt_cyc), 2);
            check("t1_spacing", 32'(pop_cyc[1] - pop_cyc[0]), 2);
        end

        // Decoder stalled: buffer fills to DEPTH and fetch stops.
        ready_pct = 0;
        for (int k = 0; k < 10; k++) cycle(0, 0);
        check("t2_req_off", 32'(imem_req), 0);
        check("t2_valid", 32'(inst_valid), 1);
        gnt_pct = 0; ready_pct = 100; p0 = n_pops;
        for (int k = 0; k < 10 && inst_valid; k++) cycle(0, 0);
        check("t2_drained", 32'(n_pops - p0), DEPTH);

        // Redirect while waiting on a slow response.
        gnt_pct = 100; lat_min = 3; lat_max = 3;
        for (int k = 0; k < 20 && !(out_busy && !imem_req); k++) cycle(0, 0);
        check("t3_in_wait", 32'(out_busy && !imem_req), 1);
        d0 = n_drops;
        cycle(1, 32'h8000_0103);
        for (int k = 0; k < 20 && !imem_req; k++) cycle(0, 0);
        check("t3_req", 32'(imem_req), 1);
        check("t3_addr", imem_addr, 32'h8000_0100);
        check("t3_dropped", 32'(n_drops - d0), 1);
        check("t3_req_after_drop", 32'(cyc - last_drop_cyc), 1);
        for (int k = 0; k < 20 && !inst_valid; k++) cycle(0, 0);
        check("t3_first_pc", inst_pc, 32'h8000_0100);

        // Redirect coinciding with a grant and a pop.
        lat_min = 0; lat_max = 0;
        for (int k = 0; k < 20 && !(inst_valid && imem_req); k++) cycle(0, 0);
        check("t4_setup", 32'(inst_valid && imem_req), 1);
        d0 = n_drops;
        cycle(1, 32'h0000_1000);
        check("t4_flushed", 32'(inst_valid), 0);
        check("t4_req_dropped", 32'(imem_req), 0);
        cycle(0, 0);
        check("t4_one_discard", 32'(n_drops - d0), 1);
        check("t4_req", 32'(imem_req), 1);
        check("t4_addr", imem_addr, 32'h0000_1000);
        for (int k = 0; k < 20 && !inst_valid; k++) cycle(0, 0);
        check("t4_next_pc", inst_pc, 32'h0000_1000);
        check("t4_next_inst", inst, word(32'h0000_1000));

        // PC wraps past the top of the address space.
        cycle(1, 32'hFFFF_FFFC);
        gnt_log.delete();
        for (int k = 0; k < 40 && gnt_log.size() < 3; k++) cycle(0, 0);
        check("t5_nfetch", gnt_log.size(), 3);
        if (gnt_log.size() >= 3) begin
            check("t5_addr0", gnt_log[0], 32'hFFFF_FFFC);
            check("t5_addr1", gnt_log[1], 32'h0000_0000);
            check("t5_addr2", gnt_log[2], 32'h0000_0004);
        end

        // Randomized memory latency, grants, decoder readiness and redirects.
        gnt_pct = 60; ready_pct = 60; lat_min = 0; lat_max = 3; p0 = n_pops;
        for (int k = 0; k < 1500; k++) cycle($urandom_range(99) < 3, $urandom);
        check("rand_progress", 32'(n_pops - p0 > 50), 1);

        // Reset in the middle of a fetch with buffered data.
        ready_pct = 0; gnt_pct = 100; lat_min = 3; lat_max = 3;
        for (int k = 0; k < 30 && !(q.size() >= 1 && out_busy); k++) cycle(0, 0);
        check("t6_setup", 32'(inst_valid && out_busy), 1);
        do_reset();
        ready_pct = 100; lat_min = 0; lat_max = 0;
        for (int k = 0; k < 5 && !imem_req; k++) cycle(0, 0);
        check("t6_req", 32'(imem_req), 1);
        check("t6_reset_pc", imem_addr, RESET_PC);
        for (int k = 0; k < 6; k++) cycle(0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
